// File: rtl/led_cube_uart_rx.sv
// UART 8N1 receiver for the LED cube controller.
// The rx pin is synchronised, then each bit is sampled near its midpoint.
// Every good byte is presented with a one-cycle read strobe.
// A low stop bit raises frame_err, and the receiver then waits out a held-low (break) line.
module led_cube_uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] uart_byte,
  output logic       read,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             byte_q, byte_d;
  logic                   read_q, read_d;
  logic                   fe_q, fe_d;
  logic                   rxs;

  // Shift the raw pin through the synchroniser chain; idle-high reset avoids a false start
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // Frame state machine: midpoint sampling, with a bit counter that restarts at every sample point
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    read_d    = 1'b0;
    fe_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A line that is already high again was a glitch, not a start bit
          state_d   = rxs ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          shift_d[bit_idx_q] = rxs;
          cnt_d              = '0;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxs) begin
            byte_d  = shift_q;
            read_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; an asynchronous reset drops everything back to idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      read_q    <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      read_q    <= read_d;
      fe_q      <= fe_d;
    end
  end

  assign uart_byte = byte_q;
  assign read      = read_q;
  assign frame_err = fe_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_led_cube_uart_rx.sv
// Directed bench for led_cube_uart_rx with 16 clocks per bit and a 2-stage synchroniser.
module tb_led_cube_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] uart_byte;
  logic       read;
  logic       frame_err;
  logic       busy;

  int tests = 0;
  int fails = 0;

  int       cyc = 0;
  int       rd_cnt = 0;
  int       fe_cnt = 0;
  int       both_cnt = 0;
  int       rd_cyc = 0;
  logic     busy_seen = 1'b0;
  logic [7:0] rd_q[$];

  led_cube_uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .uart_byte(uart_byte),
    .read(read), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record strobes away from the active edge
  always @(negedge clk) begin
    if (read) begin
      rd_cnt <= rd_cnt + 1;
      rd_cyc <= cyc;
      rd_q.push_back(uart_byte);
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (read && frame_err) both_cnt <= both_cnt + 1;
    if (busy) busy_seen <= 1'b1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0; idle(CPB);
    for (int i = 0; i < 8; i++) begin rx = b[i]; idle(CPB); end
    rx = stop; idle(CPB);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx = 1'b1;
    idle(3);
    tests++;
    if (uart_byte !== 8'h00 || read !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_vals: byte=%h read=%b fe=%b busy=%b, want 00/0/0/0", uart_byte, read, frame_err, busy);
    end
    rst_n = 1'b1;
    busy_seen = 1'b0;
    idle(500);
    tests++;
    if (rd_cnt !== 0 || fe_cnt !== 0 || busy_seen !== 1'b0 || uart_byte !== 8'h00) begin
      fails++;
      $display("FAIL idle_quiet: reads=%0d fe=%0d busy_seen=%b byte=%h, want 0/0/0/00", rd_cnt, fe_cnt, busy_seen, uart_byte);
    end
  endtask

  task automatic test_single;
    int r0, c0, lat;
    r0 = rd_cnt;
    rd_q.delete();
    c0 = cyc;
    send_frame(8'hA5, 1'b1);
    idle(10);
    tests++;
    if (rd_cnt - r0 !== 1 || rd_q.size() != 1 || rd_q[0] !== 8'hA5) begin
      fails++;
      $display("FAIL single_byte: reads=%0d first=%h, want 1/a5", rd_cnt - r0, (rd_q.size() > 0) ? rd_q[0] : 8'hxx);
    end
    lat = rd_cyc - c0;
    tests++;
    if (lat < 153 || lat > 155) begin
      fails++;
      $display("FAIL latency: got %0d cycles, want 153..155", lat);
    end
    tests++;
    if (uart_byte !== 8'hA5) begin
      fails++;
      $display("FAIL byte_hold: got %h, want a5", uart_byte);
    end
  endtask

  task automatic test_back_to_back;
    int r0, f0;
    logic [7:0] exp [3];
    exp[0] = 8'h31; exp[1] = 8'h0F; exp[2] = 8'hFF;
    r0 = rd_cnt; f0 = fe_cnt;
    rd_q.delete();
    for (int k = 0; k < 3; k++) send_frame(exp[k], 1'b1);
    idle(20);
    tests++;
    if (rd_cnt - r0 !== 3 || fe_cnt - f0 !== 0) begin
      fails++;
      $display("FAIL b2b_count: reads=%0d fe=%0d, want 3/0", rd_cnt - r0, fe_cnt - f0);
    end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (k >= rd_q.size() || rd_q[k] !== exp[k]) begin
        fails++;
        $display("FAIL b2b_byte%0d: got %h, want %h", k, (k < rd_q.size()) ? rd_q[k] : 8'hxx, exp[k]);
      end
    end
  endtask

  task automatic test_glitch;
    int r0, f0, waited;
    r0 = rd_cnt; f0 = fe_cnt;
    busy_seen = 1'b0;
    rx = 1'b0; idle(5);
    rx = 1'b1;
    waited = 0;
    while (busy !== 1'b0 && waited < 12) begin idle(1); waited++; end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL glitch_idle: busy=%b after %0d cycles, want 0 within 12", busy, waited);
    end
    tests++;
    if (busy_seen !== 1'b1) begin
      fails++;
      $display("FAIL glitch_start: busy_seen=%b, want 1", busy_seen);
    end
    idle(40);
    tests++;
    if (rd_cnt - r0 !== 0 || fe_cnt - f0 !== 0 || uart_byte !== 8'hFF) begin
      fails++;
      $display("FAIL glitch_quiet: reads=%0d fe=%0d byte=%h, want 0/0/ff", rd_cnt - r0, fe_cnt - f0, uart_byte);
    end
  endtask

  task automatic test_break;
    int r0, f0, bad;
    r0 = rd_cnt; f0 = fe_cnt; bad = 0;
    send_frame(8'h3C, 1'b0);
    for (int i = 0; i < 400; i++) begin
      idle(1);
      if (uart_byte !== 8'hFF) bad++;
    end
    tests++;
    if (fe_cnt - f0 !== 1 || rd_cnt - r0 !== 0 || bad != 0) begin
      fails++;
      $display("FAIL break: fe=%0d reads=%0d byte_changes=%0d, want 1/0/0", fe_cnt - f0, rd_cnt - r0, bad);
    end
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL break_busy: got %b, want 1", busy);
    end
    rx = 1'b1; idle(40);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL break_exit: busy=%b, want 0", busy);
    end
    rd_q.delete();
    send_frame(8'h55, 1'b1);
    idle(10);
    tests++;
    if (rd_cnt - r0 !== 1 || rd_q.size() != 1 || rd_q[0] !== 8'h55 || fe_cnt - f0 !== 1) begin
      fails++;
      $display("FAIL after_break: reads=%0d byte=%h fe=%0d, want 1/55/1", rd_cnt - r0, uart_byte, fe_cnt - f0);
    end
  endtask

  task automatic test_reset_midframe;
    int r0, f0;
    logic [7:0] b;
    b = 8'hC3;
    r0 = rd_cnt; f0 = fe_cnt;
    rx = 1'b0; idle(CPB);
    for (int i = 0; i < 4; i++) begin rx = b[i]; idle(CPB); end
    rx = b[4]; idle(5);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_busy: got %b, want 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (uart_byte !== 8'h00 || busy !== 1'b0 || read !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: byte=%h busy=%b read=%b fe=%b, want 00/0/0/0", uart_byte, busy, read, frame_err);
    end
    rx = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(60);
    tests++;
    if (rd_cnt - r0 !== 0 || fe_cnt - f0 !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL aborted_frame: reads=%0d fe=%0d busy=%b, want 0/0/0", rd_cnt - r0, fe_cnt - f0, busy);
    end
    rd_q.delete();
    send_frame(8'h81, 1'b1);
    idle(10);
    tests++;
    if (rd_cnt - r0 !== 1 || rd_q.size() != 1 || rd_q[0] !== 8'h81) begin
      fails++;
      $display("FAIL post_reset_byte: reads=%0d byte=%h, want 1/81", rd_cnt - r0, uart_byte);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_midframe();
    tests++;
    if (both_cnt !== 0) begin
      fails++;
      $display("FAIL strobe_overlap: got %0d cycles with read and frame_err, want 0", both_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
